// File: rtl/id_ex_hazard_stage_if.sv
// ID-to-EX boundary of the pipeline: decoded control, operands and register indices
// coming from ID, their registered copies going to EX, and the hazard/bubble status.
interface id_ex_hazard_stage_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 Hold_in;
  logic                 RegWrite_in;
  logic                 MemWrite_in;
  logic                 ALUSrc_in;
  logic                 Branch_in;
  logic                 MemRead_in;
  logic [2:0]           ALUOp_in;
  logic [XLEN-1:0]      RS1data_in;
  logic [XLEN-1:0]      RS2data_in;
  logic [XLEN-1:0]      Imm_in;
  logic [4:0]           RS1addr_in;
  logic [4:0]           RS2addr_in;
  logic [4:0]           RDaddr_in;

  logic                 RegWrite_out;
  logic                 MemWrite_out;
  logic                 ALUSrc_out;
  logic                 MemRead_out;
  logic [2:0]           ALUOp_out;
  logic [XLEN-1:0]      RS1data_out;
  logic [XLEN-1:0]      RS2data_out;
  logic [XLEN-1:0]      Imm_out;
  logic [4:0]           RS1addr_out;
  logic [4:0]           RS2addr_out;
  logic [4:0]           RDaddr_out;
  logic                 Stall_out;
  logic [CNT_WIDTH-1:0] BubbleCnt_out;

  // Flow control: there is no valid/ready pair. Stall_out=1 means the ID instruction
  // is not accepted this edge (PC and IF/ID must hold it); Hold_in=1 freezes this stage.
  modport master (
    output Hold_in, RegWrite_in, MemWrite_in, ALUSrc_in, Branch_in, MemRead_in, ALUOp_in,
           RS1data_in, RS2data_in, Imm_in, RS1addr_in, RS2addr_in, RDaddr_in,
    input  RegWrite_out, MemWrite_out, ALUSrc_out, MemRead_out, ALUOp_out,
           RS1data_out, RS2data_out, Imm_out, RS1addr_out, RS2addr_out, RDaddr_out,
           Stall_out, BubbleCnt_out
  );

  modport slave (
    input  Hold_in, RegWrite_in, MemWrite_in, ALUSrc_in, Branch_in, MemRead_in, ALUOp_in,
           RS1data_in, RS2data_in, Imm_in, RS1addr_in, RS2addr_in, RDaddr_in,
    output RegWrite_out, MemWrite_out, ALUSrc_out, MemRead_out, ALUOp_out,
           RS1data_out, RS2data_out, Imm_out, RS1addr_out, RS2addr_out, RDaddr_out,
           Stall_out, BubbleCnt_out
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a
// saturating count of inserted bubbles.
module id_ex_hazard_stage #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  id_ex_hazard_stage_if.slave bus
);

  logic                 ex_regwrite;
  logic                 ex_memwrite;
  logic                 ex_alusrc;
  logic                 ex_memread;
  logic [2:0]           ex_aluop;
  logic [XLEN-1:0]      ex_rs1data;
  logic [XLEN-1:0]      ex_rs2data;
  logic [XLEN-1:0]      ex_imm;
  logic [4:0]           ex_rs1addr;
  logic [4:0]           ex_rs2addr;
  logic [4:0]           ex_rdaddr;
  logic [CNT_WIDTH-1:0] bubble_cnt;

  logic id_live;
  logic id_uses_rs2;
  logic hazard;

  // An ID slot with no side effects (all-zero control) is a bubble and never stalls.
  always_comb begin
    id_live     = bus.RegWrite_in | bus.MemWrite_in | bus.Branch_in | bus.MemRead_in;
    id_uses_rs2 = id_live & (~bus.ALUSrc_in | bus.MemWrite_in);
    hazard      = ex_memread & (ex_rdaddr != 5'd0) & id_live &
                  ((ex_rdaddr == bus.RS1addr_in) |
                   (id_uses_rs2 & (ex_rdaddr == bus.RS2addr_in)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_regwrite <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memread  <= 1'b0;
      ex_aluop    <= 3'd0;
      ex_rs1data  <= '0;
      ex_rs2data  <= '0;
      ex_imm      <= '0;
      ex_rs1addr  <= 5'd0;
      ex_rs2addr  <= 5'd0;
      ex_rdaddr   <= 5'd0;
      bubble_cnt  <= '0;
    end else if (!bus.Hold_in) begin
      // On a hazard only the control fields are squashed; data fields are don't-care.
      ex_regwrite <= hazard ? 1'b0 : bus.RegWrite_in;
      ex_memwrite <= hazard ? 1'b0 : bus.MemWrite_in;
      ex_alusrc   <= hazard ? 1'b0 : bus.ALUSrc_in;
      ex_memread  <= hazard ? 1'b0 : bus.MemRead_in;
      ex_aluop    <= hazard ? 3'd0 : bus.ALUOp_in;
      ex_rs1data  <= bus.RS1data_in;
      ex_rs2data  <= bus.RS2data_in;
      ex_imm      <= bus.Imm_in;
      ex_rs1addr  <= bus.RS1addr_in;
      ex_rs2addr  <= bus.RS2addr_in;
      ex_rdaddr   <= bus.RDaddr_in;
      if (hazard && (bubble_cnt != {CNT_WIDTH{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.RegWrite_out  = ex_regwrite;
  assign bus.MemWrite_out  = ex_memwrite;
  assign bus.ALUSrc_out    = ex_alusrc;
  assign bus.MemRead_out   = ex_memread;
  assign bus.ALUOp_out     = ex_aluop;
  assign bus.RS1data_out   = ex_rs1data;
  assign bus.RS2data_out   = ex_rs2data;
  assign bus.Imm_out       = ex_imm;
  assign bus.RS1addr_out   = ex_rs1addr;
  assign bus.RS2addr_out   = ex_rs2addr;
  assign bus.RDaddr_out    = ex_rdaddr;
  assign bus.Stall_out     = hazard;
  assign bus.BubbleCnt_out = bubble_cnt;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed and randomized bench for id_ex_hazard_stage, checked against a
// behavioural model of what EX should see after each edge.
module tb_id_ex_hazard_stage;
  localparam int XLEN      = 32;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_i;

  id_ex_hazard_stage_if #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) bus ();

  id_ex_hazard_stage #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rw, mw, as, mr;
    logic [2:0]      op;
    logic [XLEN-1:0] r1, r2, imm;
    logic [4:0]      a1, a2, rd;
  } ex_t;

  ex_t m;
  int  m_cnt;
  bit  m_valid;
  int  total;
  int  bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load-use rule evaluated on the instruction currently presented by ID.
  function automatic bit model_hazard();
    bit live, rs2_used;
    live     = bus.RegWrite_in | bus.MemWrite_in | bus.Branch_in | bus.MemRead_in;
    rs2_used = live && (!bus.ALUSrc_in || bus.MemWrite_in);
    if (!m.mr || m.rd == 0 || !live) return 0;
    return (m.rd == bus.RS1addr_in) || (rs2_used && m.rd == bus.RS2addr_in);
  endfunction

  task automatic drive(input bit rw, mw, as, br, mr, input int op, a1, a2, rd);
    bus.RegWrite_in = rw;
    bus.MemWrite_in = mw;
    bus.ALUSrc_in   = as;
    bus.Branch_in   = br;
    bus.MemRead_in  = mr;
    bus.ALUOp_in    = 3'(op);
    bus.RS1addr_in  = 5'(a1);
    bus.RS2addr_in  = 5'(a2);
    bus.RDaddr_in   = 5'(rd);
    bus.RS1data_in  = $urandom;
    bus.RS2data_in  = $urandom;
    bus.Imm_in      = $urandom;
  endtask

  task automatic check_outputs();
    check("regwrite", 64'(bus.RegWrite_out), 64'(m.rw));
    check("memwrite", 64'(bus.MemWrite_out), 64'(m.mw));
    check("alusrc",   64'(bus.ALUSrc_out),   64'(m.as));
    check("memread",  64'(bus.MemRead_out),  64'(m.mr));
    check("aluop",    64'(bus.ALUOp_out),    64'(m.op));
    check("rs1data",  64'(bus.RS1data_out),  64'(m.r1));
    check("rs2data",  64'(bus.RS2data_out),  64'(m.r2));
    check("imm",      64'(bus.Imm_out),      64'(m.imm));
    check("rs1addr",  64'(bus.RS1addr_out),  64'(m.a1));
    check("rs2addr",  64'(bus.RS2addr_out),  64'(m.a2));
    check("rdaddr",   64'(bus.RDaddr_out),   64'(m.rd));
    check("bubblecnt", 64'(bus.BubbleCnt_out), 64'(m_cnt));
  endtask

  // One clock: check Stall before the edge, advance the model at the edge, check EX after.
  task automatic step(input bit rst, input bit hold, output logic stall_seen);
    bit hz;
    rst_i       = rst;
    bus.Hold_in = hold;
    #1;
    hz         = model_hazard();
    stall_seen = bus.Stall_out;
    if (m_valid) check("stall", 64'(bus.Stall_out), 64'(hz));
    @(posedge clk);
    if (rst) begin
      m       = '{default: '0};
      m_cnt   = 0;
      m_valid = 1;
    end else if (!hold) begin
      m.rw  = hz ? 1'b0 : bus.RegWrite_in;
      m.mw  = hz ? 1'b0 : bus.MemWrite_in;
      m.as  = hz ? 1'b0 : bus.ALUSrc_in;
      m.mr  = hz ? 1'b0 : bus.MemRead_in;
      m.op  = hz ? 3'd0 : bus.ALUOp_in;
      m.r1  = bus.RS1data_in;
      m.r2  = bus.RS2data_in;
      m.imm = bus.Imm_in;
      m.a1  = bus.RS1addr_in;
      m.a2  = bus.RS2addr_in;
      m.rd  = bus.RDaddr_in;
      if (hz && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
    if (m_valid) check_outputs();
  endtask

  task automatic lw5();
    drive(1, 0, 1, 0, 1, 0, 1, 0, 5);
  endtask

  initial begin
    logic st;
    total   = 0;
    bad     = 0;
    m       = '{default: '0};
    m_cnt   = 0;
    m_valid = 0;
    rst_i   = 1'b1;
    bus.Hold_in = 1'b0;

    // Reset for two cycles with random inputs
    drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31));
    step(1, 0, st);
    step(1, $urandom_range(0, 1), st);
    check("reset_stall", 64'(bus.Stall_out), 64'(0));
    check("reset_cnt", 64'(bus.BubbleCnt_out), 64'(0));

    // add x3,x1,x2 passes through with 1-cycle latency
    drive(1, 0, 0, 0, 0, 2, 1, 2, 3);
    step(0, 0, st);
    check("pass_stall", 64'(st), 64'(0));
    check("pass_rd", 64'(bus.RDaddr_out), 64'(3));
    check("pass_aluop", 64'(bus.ALUOp_out), 64'(2));

    // lw x5; add x6,x5,x7 -> one bubble
    lw5();
    step(0, 0, st);
    drive(1, 0, 0, 0, 0, 2, 5, 7, 6);
    step(0, 0, st);
    check("lu_stall", 64'(st), 64'(1));
    check("lu_bubble_rw", 64'(bus.RegWrite_out), 64'(0));
    step(0, 0, st);
    check("lu_release", 64'(st), 64'(0));
    check("lu_add_rd", 64'(bus.RDaddr_out), 64'(6));
    check("lu_cnt", 64'(bus.BubbleCnt_out), 64'(1));

    // lw x5; addi x6,x0,imm with rs2 field = 5 -> no stall
    lw5();
    step(0, 0, st);
    drive(1, 0, 1, 0, 0, 0, 0, 5, 6);
    step(0, 0, st);
    check("rs2_filter", 64'(st), 64'(0));

    // lw x5; sw x5,0(x1) -> one bubble
    lw5();
    step(0, 0, st);
    drive(0, 1, 1, 0, 0, 0, 1, 5, 0);
    step(0, 0, st);
    check("store_stall", 64'(st), 64'(1));
    step(0, 0, st);
    check("store_release", 64'(st), 64'(0));
    check("store_cnt", 64'(bus.BubbleCnt_out), 64'(2));

    // lw x0; add reading x0 -> no stall
    drive(1, 0, 1, 0, 1, 0, 1, 0, 0);
    step(0, 0, st);
    drive(1, 0, 0, 0, 0, 2, 0, 0, 6);
    step(0, 0, st);
    check("x0_stall", 64'(st), 64'(0));

    // Hold during a hazard: frozen, stall still asserted, count unchanged
    lw5();
    step(0, 0, st);
    drive(1, 0, 0, 0, 0, 2, 5, 7, 6);
    step(0, 1, st);
    check("hold_stall", 64'(st), 64'(1));
    check("hold_memread", 64'(bus.MemRead_out), 64'(1));
    check("hold_cnt", 64'(bus.BubbleCnt_out), 64'(2));
    step(0, 0, st);
    check("hold_bubble_cnt", 64'(bus.BubbleCnt_out), 64'(3));
    step(0, 0, st);
    check("hold_release", 64'(st), 64'(0));

    // Reset mid-stall clears the load and the counter
    lw5();
    step(0, 0, st);
    drive(1, 0, 0, 0, 0, 2, 5, 7, 6);
    step(1, 0, st);
    check("rst_mid_stall_seen", 64'(st), 64'(1));
    step(0, 0, st);
    check("rst_mid_release", 64'(st), 64'(0));
    check("rst_mid_cnt", 64'(bus.BubbleCnt_out), 64'(0));

    // Saturation of the bubble counter
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      lw5();
      step(0, 0, st);
      drive(0, 0, 0, 1, 0, 0, 5, 5, 0);
      step(0, 0, st);
    end
    check("sat_cnt", 64'(bus.BubbleCnt_out), 64'(CNT_MAX));

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 1),
            $urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
